// File: rtl/cpu_pkg.sv
// Shared CPU definitions: RISC-V funct3 branch-condition encodings and the
// writeback result-source select values used by the pipeline stages.
package cpu_pkg;

  typedef enum logic [2:0] {
    BR_EQ   = 3'b000,
    BR_NE   = 3'b001,
    BR_RSV2 = 3'b010,
    BR_RSV3 = 3'b011,
    BR_LT   = 3'b100,
    BR_GE   = 3'b101,
    BR_LTU  = 3'b110,
    BR_GEU  = 3'b111
  } branch_cond_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } result_src_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation from the ALU status flags of A-B.
// The carry flag means "borrow", i.e. it is set when A < B unsigned.
module branch_cond_eval
  import cpu_pkg::*;
(
  input  logic       neg_flag,
  input  logic       zero_flag,
  input  logic       carry_flag,
  input  logic       v_flag,
  input  logic [2:0] branch_cond,
  output logic       cond_met
);

  always_comb begin
    cond_met = 1'b0;
    unique case (branch_cond_e'(branch_cond))
      BR_EQ:   cond_met = zero_flag;
      BR_NE:   cond_met = ~zero_flag;
      BR_LT:   cond_met = neg_flag ^ v_flag;
      BR_GE:   cond_met = ~(neg_flag ^ v_flag);
      BR_LTU:  cond_met = carry_flag;
      BR_GEU:  cond_met = ~carry_flag;
      default: cond_met = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch resolution and control-flow redirect.
// Optional performance counters are enabled by defining EX_MEM_PERF_CNT_EN.
module ex_mem_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic [WIDTH-1:0] write_data_i,
  input  logic [WIDTH-1:0] pc_target_i,
  input  logic             neg_flag_i,
  input  logic             zero_flag_i,
  input  logic             carry_flag_i,
  input  logic             v_flag_i,
  input  logic             branch_i,
  input  logic             jump_i,
  input  logic [2:0]       branch_cond_i,
  input  logic [4:0]       rd_i,
  input  logic             reg_write_i,
  input  logic             mem_write_i,
  input  logic [1:0]       result_src_i,
`ifdef EX_MEM_PERF_CNT_EN
  output logic [31:0]      taken_cnt_o,
  output logic [31:0]      bubble_cnt_o,
`endif
  output logic             valid_o,
  output logic [WIDTH-1:0] alu_result_o,
  output logic [WIDTH-1:0] write_data_o,
  output logic [4:0]       rd_o,
  output logic             reg_write_o,
  output logic             mem_write_o,
  output logic [1:0]       result_src_o,
  output logic             redirect_o,
  output logic [WIDTH-1:0] redirect_target_o
);

  logic cond_met;
  logic taken;
  logic load;

  branch_cond_eval u_branch_cond_eval (
    .neg_flag    (neg_flag_i),
    .zero_flag   (zero_flag_i),
    .carry_flag  (carry_flag_i),
    .v_flag      (v_flag_i),
    .branch_cond (branch_cond_i),
    .cond_met    (cond_met)
  );

  assign taken = valid_i & (jump_i | (branch_i & cond_met));
  assign load  = ~flush_i & ~stall_i;

  // Flush only squashes the control bits; data fields keep their old values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_o           <= 1'b0;
      alu_result_o      <= '0;
      write_data_o      <= '0;
      rd_o              <= '0;
      reg_write_o       <= 1'b0;
      mem_write_o       <= 1'b0;
      result_src_o      <= RES_ALU;
      redirect_o        <= 1'b0;
      redirect_target_o <= '0;
    end else if (flush_i) begin
      valid_o     <= 1'b0;
      reg_write_o <= 1'b0;
      mem_write_o <= 1'b0;
      redirect_o  <= 1'b0;
    end else if (load) begin
      valid_o           <= valid_i;
      alu_result_o      <= alu_result_i;
      write_data_o      <= write_data_i;
      rd_o              <= rd_i;
      reg_write_o       <= valid_i & reg_write_i;
      mem_write_o       <= valid_i & mem_write_i;
      result_src_o      <= result_src_i;
      redirect_o        <= taken;
      redirect_target_o <= pc_target_i;
    end
  end

`ifdef EX_MEM_PERF_CNT_EN
  // A bubble is either an invalid slot loaded or a slot squashed by flush.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      taken_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else if (flush_i) begin
      bubble_cnt_o <= bubble_cnt_o + 32'd1;
    end else if (load) begin
      if (taken) begin
        taken_cnt_o <= taken_cnt_o + 32'd1;
      end
      if (!valid_i) begin
        bubble_cnt_o <= bubble_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus randomized
// branches checked against a comparison-level reference model.
module tb_ex_mem_stage;
  import cpu_pkg::*;

  localparam int WIDTH = 32;

  logic             clk_i = 1'b0;
  logic             reset_i, stall_i, flush_i, valid_i;
  logic [WIDTH-1:0] alu_result_i, write_data_i, pc_target_i;
  logic             neg_flag_i, zero_flag_i, carry_flag_i, v_flag_i;
  logic             branch_i, jump_i;
  logic [2:0]       branch_cond_i;
  logic [4:0]       rd_i;
  logic             reg_write_i, mem_write_i;
  logic [1:0]       result_src_i;
  logic             valid_o, reg_write_o, mem_write_o, redirect_o;
  logic [WIDTH-1:0] alu_result_o, write_data_o, redirect_target_o;
  logic [4:0]       rd_o;
  logic [1:0]       result_src_o;
`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0]      taken_cnt_o, bubble_cnt_o;
`endif

  ex_mem_stage #(.WIDTH(WIDTH)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .alu_result_i(alu_result_i), .write_data_i(write_data_i),
    .pc_target_i(pc_target_i), .neg_flag_i(neg_flag_i), .zero_flag_i(zero_flag_i),
    .carry_flag_i(carry_flag_i), .v_flag_i(v_flag_i), .branch_i(branch_i),
    .jump_i(jump_i), .branch_cond_i(branch_cond_i), .rd_i(rd_i),
    .reg_write_i(reg_write_i), .mem_write_i(mem_write_i), .result_src_i(result_src_i),
`ifdef EX_MEM_PERF_CNT_EN
    .taken_cnt_o(taken_cnt_o), .bubble_cnt_o(bubble_cnt_o),
`endif
    .valid_o(valid_o), .alu_result_o(alu_result_o), .write_data_o(write_data_o),
    .rd_o(rd_o), .reg_write_o(reg_write_o), .mem_write_o(mem_write_o),
    .result_src_o(result_src_o), .redirect_o(redirect_o),
    .redirect_target_o(redirect_target_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model of what the stage should hold after each edge
  logic             m_valid, m_reg_write, m_mem_write, m_redirect;
  logic [WIDTH-1:0] m_alu, m_wd, m_target;
  logic [4:0]       m_rd;
  logic [1:0]       m_rs;
  logic [31:0]      m_taken_cnt, m_bubble_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setIdle();
    reset_i = 0; stall_i = 0; flush_i = 0; valid_i = 0;
    alu_result_i = '0; write_data_i = '0; pc_target_i = '0;
    neg_flag_i = 0; zero_flag_i = 0; carry_flag_i = 0; v_flag_i = 0;
    branch_i = 0; jump_i = 0; branch_cond_i = 3'b010;
    rd_i = '0; reg_write_i = 0; mem_write_i = 0; result_src_i = '0;
  endtask

  task automatic modelReset();
    m_valid = 0; m_reg_write = 0; m_mem_write = 0; m_redirect = 0;
    m_alu = '0; m_wd = '0; m_target = '0; m_rd = '0; m_rs = '0;
    m_taken_cnt = '0; m_bubble_cnt = '0;
  endtask

  // Advance one clock; exp_taken is the bench's own verdict for the current inputs
  task automatic applyStimulus(input logic exp_taken);
    if (reset_i) modelReset();
    else if (flush_i) begin
      m_valid = 0; m_reg_write = 0; m_mem_write = 0; m_redirect = 0;
      m_bubble_cnt = m_bubble_cnt + 1;
    end else if (!stall_i) begin
      m_valid = valid_i; m_alu = alu_result_i; m_wd = write_data_i;
      m_rd = rd_i; m_rs = result_src_i; m_target = pc_target_i;
      m_reg_write = valid_i && reg_write_i;
      m_mem_write = valid_i && mem_write_i;
      m_redirect = exp_taken;
      if (exp_taken) m_taken_cnt = m_taken_cnt + 1;
      if (!valid_i) m_bubble_cnt = m_bubble_cnt + 1;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".valid"},     32'(valid_o),           32'(m_valid));
    check({tag, ".alu"},       alu_result_o,           m_alu);
    check({tag, ".wdata"},     write_data_o,           m_wd);
    check({tag, ".rd"},        32'(rd_o),              32'(m_rd));
    check({tag, ".regwr"},     32'(reg_write_o),       32'(m_reg_write));
    check({tag, ".memwr"},     32'(mem_write_o),       32'(m_mem_write));
    check({tag, ".rsrc"},      32'(result_src_o),      32'(m_rs));
    check({tag, ".redirect"},  32'(redirect_o),        32'(m_redirect));
    check({tag, ".target"},    redirect_target_o,      m_target);
`ifdef EX_MEM_PERF_CNT_EN
    check({tag, ".taken_cnt"},  taken_cnt_o,  m_taken_cnt);
    check({tag, ".bubble_cnt"}, bubble_cnt_o, m_bubble_cnt);
`endif
    @(negedge clk_i);
  endtask

  // Random compare of operands a,b: flags come from a-b, verdict from direct comparison
  task automatic randomBranch(output logic exp_taken);
    logic [31:0] a, b, diff;
    logic        cmp;
    a = $urandom;
    b = ($urandom_range(0, 3) == 0) ? a : $urandom;
    if ($urandom_range(0, 3) == 0) b = {~a[31], a[30:0]};
    diff = a - b;
    zero_flag_i  = (diff == 0);
    neg_flag_i   = diff[31];
    carry_flag_i = (a < b);
    v_flag_i     = (a[31] != b[31]) && (diff[31] != a[31]);
    branch_cond_i = 3'($urandom_range(0, 7));
    case (branch_cond_i)
      3'b000:  cmp = (a == b);
      3'b001:  cmp = (a != b);
      3'b100:  cmp = ($signed(a) <  $signed(b));
      3'b101:  cmp = ($signed(a) >= $signed(b));
      3'b110:  cmp = (a <  b);
      3'b111:  cmp = (a >= b);
      default: cmp = 1'b0;
    endcase
    valid_i  = ($urandom_range(0, 5) != 0);
    branch_i = $urandom_range(0, 1) == 1;
    jump_i   = ($urandom_range(0, 5) == 0);
    exp_taken = valid_i && (jump_i || (branch_i && cmp));
    alu_result_i = $urandom; write_data_i = $urandom; pc_target_i = $urandom;
    rd_i = 5'($urandom); result_src_i = 2'($urandom);
    reg_write_i = $urandom_range(0, 1) == 1;
    mem_write_i = $urandom_range(0, 1) == 1;
    stall_i = ($urandom_range(0, 6) == 0);
    flush_i = ($urandom_range(0, 8) == 0);
  endtask

  initial begin
    logic t;
    setIdle();
    modelReset();
    @(negedge clk_i);

    reset_i = 1;
    alu_result_i = 32'h1234_5678; valid_i = 1; reg_write_i = 1;
    applyStimulus(1'b0); checkOutput("reset");
    setIdle();

    // BEQ taken then a non-branch instruction
    valid_i = 1; branch_i = 1; branch_cond_i = 3'b000; zero_flag_i = 1;
    pc_target_i = 32'h100; reg_write_i = 1; rd_i = 5'd3;
    applyStimulus(1'b1);
    check("beq.redirect", 32'(redirect_o), 32'd1);
    check("beq.target", redirect_target_o, 32'h100);
    checkOutput("beq");
    branch_i = 0; zero_flag_i = 0; pc_target_i = 32'h0;
    applyStimulus(1'b0);
    check("beq.after", 32'(redirect_o), 32'd0);
    checkOutput("beq_next");

    // BLT with overflow is taken; BGEU with borrow is not
    branch_i = 1; branch_cond_i = 3'b100; neg_flag_i = 0; v_flag_i = 1; pc_target_i = 32'h200;
    applyStimulus(1'b1); checkOutput("blt_ovf");
    branch_cond_i = 3'b111; v_flag_i = 0; carry_flag_i = 1; pc_target_i = 32'h300;
    applyStimulus(1'b0); checkOutput("bgeu_borrow");
    setIdle();

    // Stall: hold DEADBEEF and ignore a taken jump offered meanwhile
    valid_i = 1; alu_result_i = 32'hDEAD_BEEF; reg_write_i = 1; mem_write_i = 1;
    applyStimulus(1'b0); checkOutput("pre_stall");
    stall_i = 1; jump_i = 1; pc_target_i = 32'h400;
    for (int i = 0; i < 3; i++) begin
      alu_result_i = 32'h1000 + 32'(i);
      applyStimulus(1'b1);
      check("stall.alu", alu_result_o, 32'hDEAD_BEEF);
      check("stall.redirect", 32'(redirect_o), 32'd0);
      checkOutput("stall");
    end

    // A captured redirect is held by a following stall
    stall_i = 0;
    applyStimulus(1'b1); checkOutput("jump_load");
    stall_i = 1; jump_i = 0;
    applyStimulus(1'b0); checkOutput("redirect_hold");

    // Flush beats stall and squashes a taken branch
    flush_i = 1; jump_i = 1; pc_target_i = 32'h500;
    applyStimulus(1'b1);
    check("flush.valid", 32'(valid_o), 32'd0);
    check("flush.redirect", 32'(redirect_o), 32'd0);
    check("flush.regwr", 32'(reg_write_o), 32'd0);
    checkOutput("flush_stall");
    setIdle();

    // Bubble: invalid slot clears write enables and redirect
    valid_i = 0; reg_write_i = 1; mem_write_i = 1; jump_i = 1; alu_result_i = 32'h55;
    applyStimulus(1'b0); checkOutput("bubble");
    setIdle();

    for (int i = 0; i < 60; i++) begin
      randomBranch(t);
      applyStimulus(t); checkOutput("random");
    end
    setIdle();

    // Reset during stall and flush overrides; next load is normal
    stall_i = 1; flush_i = 1; reset_i = 1; valid_i = 1; jump_i = 1;
    applyStimulus(1'b0); checkOutput("reset_mid");
    setIdle();
    valid_i = 1; jump_i = 1; pc_target_i = 32'h600; reg_write_i = 1; alu_result_i = 32'h77;
    applyStimulus(1'b1); checkOutput("post_reset_load");
    setIdle();

`ifdef EX_MEM_PERF_CNT_EN
    reset_i = 1;
    applyStimulus(1'b0); checkOutput("cnt_reset");
    setIdle();
    valid_i = 1; jump_i = 1;
    applyStimulus(1'b1); applyStimulus(1'b1);
    check("cnt.two_taken", taken_cnt_o, 32'd2);
    checkOutput("cnt_two");
    force dut.taken_cnt_o = 32'hFFFF_FFFF;
    #1 release dut.taken_cnt_o;
    m_taken_cnt = 32'hFFFF_FFFF;
    applyStimulus(1'b1);
    check("cnt.wrap", taken_cnt_o, 32'd0);
    checkOutput("cnt_wrap");
    setIdle();
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
